// File: rtl/ccip_c0_rd_line_arbiter_if.sv
// Requester-side and CCI-P c0-side signal bundle for the c0 read-line arbiter.
// The slave modport is the arbiter's view; master is the AFU/platform side.
interface ccip_c0_rd_line_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*42-1:0] req_addr;
    logic [NUM_REQ*2-1:0]  req_cl_len;
    logic [NUM_REQ*16-1:0] req_mdata;
    logic                  tx_almfull;
    logic                  tx_valid;
    logic [41:0]           tx_addr;
    logic [1:0]            tx_cl_len;
    logic [15:0]           tx_mdata;
    logic                  rx_rsp_valid;
    logic [15:0]           rx_rsp_mdata;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [15:0]           rsp_mdata;

    modport master (
        output req_valid, req_addr, req_cl_len, req_mdata, tx_almfull, rx_rsp_valid, rx_rsp_mdata,
        input  req_ready, tx_valid, tx_addr, tx_cl_len, tx_mdata, rsp_valid, rsp_mdata
    );

    modport slave (
        input  req_valid, req_addr, req_cl_len, req_mdata, tx_almfull, rx_rsp_valid, rx_rsp_mdata,
        output req_ready, tx_valid, tx_addr, tx_cl_len, tx_mdata, rsp_valid, rsp_mdata
    );
endinterface

// File: rtl/ccip_c0_rd_line_arbiter.sv
// Round-robin arbiter for the CCI-P c0 read-request channel with line-credit
// accounting, mdata ID tagging, response steering and a quiesce/drain handshake.
//
// state      | meaning
// ST_RUN     | arbitration enabled (still gated by tx_almfull and credit)
// ST_DRAIN   | quiesce requested, waiting for in-flight lines to return
// ST_DRAINED | quiesced with zero lines in flight
module ccip_c0_rd_line_arbiter #(
    parameter int         NUM_REQ          = 2,
    parameter int         MAX_ACTIVE_LINES = 512,
    parameter logic [3:0] CL_LEN_MASK      = 4'b1011
) (
    input  logic                     clk,
    input  logic                     reset_n,
    ccip_c0_rd_line_arbiter_if.slave bus,
    input  logic                     quiesce,
    output logic                     drained,
    output logic [15:0]              active_lines,
    output logic                     err_len,
    output logic                     err_underflow
);
    localparam int                  IDW      = $clog2(NUM_REQ);
    localparam int                  ID_SPACE = 1 << IDW;
    localparam logic [15:0]         ID_MASK  = ~(16'hffff >> IDW);
    localparam logic [ID_SPACE-1:0] ID_OK    = ID_SPACE'((64'd1 << NUM_REQ) - 64'd1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DRAINED = 2'd2
    } state_t;

    state_t             state, state_next;
    logic               grant_en;
    logic [IDW-1:0]     rr_ptr, winner, cand;
    logic               grant_any, grant_legal, issue;
    logic [NUM_REQ-1:0] eligible;
    logic [2:0]         req_lines [NUM_REQ];
    logic [41:0]        win_addr;
    logic [1:0]         win_len;
    logic [15:0]        win_mdata;
    logic [2:0]         win_lines;
    logic [IDW-1:0]     rsp_id;
    logic               rsp_id_ok, rsp_dec;
    logic [15:0]        active_next;

    // Illegal lengths cost no credit, so they can always win and be dropped.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_lines[i] = CL_LEN_MASK[bus.req_cl_len[2*i +: 2]] ?
                           {1'b0, bus.req_cl_len[2*i +: 2]} + 3'd1 : 3'd0;
            eligible[i]  = bus.req_valid[i] && grant_en &&
                           ({1'b0, active_lines} + 17'(req_lines[i]) <= 17'(MAX_ACTIVE_LINES));
        end
    end

    always_comb begin
        grant_any = 1'b0;
        winner    = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_any && eligible[cand]) begin
                grant_any = 1'b1;
                winner    = cand;
            end
        end
    end

    always_comb begin
        win_addr  = '0;
        win_len   = '0;
        win_mdata = '0;
        win_lines = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IDW'(i)) begin
                win_addr  = bus.req_addr[42*i +: 42];
                win_len   = bus.req_cl_len[2*i +: 2];
                win_mdata = bus.req_mdata[16*i +: 16];
                win_lines = req_lines[i];
            end
        end
    end

    assign grant_legal = CL_LEN_MASK[win_len];
    assign issue       = grant_any && grant_legal;
    // Gated by reset_n so req_ready reads 0 while reset is held, even with requests pending.
    assign bus.req_ready = (grant_any && reset_n) ? NUM_REQ'(1) << winner : '0;

    assign rsp_id      = bus.rx_rsp_mdata[15 -: IDW];
    assign rsp_id_ok   = ID_OK[rsp_id];
    assign rsp_dec     = bus.rx_rsp_valid && rsp_id_ok && (active_lines != 16'd0);
    assign active_next = active_lines + (issue ? 16'(win_lines) : 16'd0) - 16'(rsp_dec);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr        <= '0;
            active_lines  <= '0;
            err_len       <= 1'b0;
            err_underflow <= 1'b0;
            bus.tx_valid  <= 1'b0;
            bus.tx_addr   <= '0;
            bus.tx_cl_len <= '0;
            bus.tx_mdata  <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_mdata <= '0;
        end else begin
            if (grant_any) begin
                rr_ptr <= (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            end
            bus.tx_valid <= issue;
            if (issue) begin
                bus.tx_addr   <= win_addr;
                bus.tx_cl_len <= win_len;
                bus.tx_mdata  <= (win_mdata & ~ID_MASK) | (16'(winner) << (16 - IDW));
            end
            if (grant_any && !grant_legal) begin
                err_len <= 1'b1;
            end
            if (bus.rx_rsp_valid && (!rsp_id_ok || active_lines == 16'd0)) begin
                err_underflow <= 1'b1;
            end
            active_lines  <= active_next;
            bus.rsp_valid <= (bus.rx_rsp_valid && rsp_id_ok) ? NUM_REQ'(1) << rsp_id : '0;
            bus.rsp_mdata <= bus.rx_rsp_mdata & ~ID_MASK;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Drain completion looks at the post-edge count so drained follows the last beat directly.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (quiesce) begin
                    state_next = (active_next == 16'd0) ? ST_DRAINED : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!quiesce) begin
                    state_next = ST_RUN;
                end else if (active_next == 16'd0) begin
                    state_next = ST_DRAINED;
                end
            end
            ST_DRAINED: begin
                if (!quiesce) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_comb begin
        grant_en = 1'b0;
        drained  = 1'b0;
        case (state)
            ST_RUN:     grant_en = !bus.tx_almfull;
            ST_DRAINED: drained  = 1'b1;
            default:    ;
        endcase
    end
endmodule

// File: tb/tb_ccip_c0_rd_line_arbiter.sv
// Directed scenarios plus randomised traffic for the c0 read-line arbiter,
// checked every cycle against a line-count/queue reference model.
module tb_ccip_c0_rd_line_arbiter;
    localparam int NR  = 2;
    localparam int MAX = 8;
    localparam int MODE_RUN     = 0;
    localparam int MODE_DRAIN   = 1;
    localparam int MODE_DRAINED = 2;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        quiesce = 1'b0;
    logic        drained;
    logic [15:0] active_lines;
    logic        err_len;
    logic        err_underflow;

    ccip_c0_rd_line_arbiter_if #(.NUM_REQ(NR)) bus ();

    ccip_c0_rd_line_arbiter #(
        .NUM_REQ(NR),
        .MAX_ACTIVE_LINES(MAX),
        .CL_LEN_MASK(4'b1011)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .quiesce(quiesce),
        .drained(drained),
        .active_lines(active_lines),
        .err_len(err_len),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    logic        r_valid [NR];
    logic [1:0]  r_len   [NR];
    logic [41:0] r_addr  [NR];
    logic [15:0] r_mdata [NR];

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_active;
    int          m_ptr;
    int          m_mode;
    bit          m_err_len;
    bit          m_err_unf;
    bit          m_tx_valid;
    logic [41:0] m_tx_addr;
    logic [1:0]  m_tx_len;
    logic [15:0] m_tx_mdata;
    logic [NR-1:0] m_rsp_valid;
    logic [15:0] m_rsp_mdata;
    int          p_grant;
    int          outq[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lines_of(input logic [1:0] len);
        case (len)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd3:    return 4;
            default: return 0;
        endcase
    endfunction

    task automatic apply();
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i]          = r_valid[i];
            bus.req_cl_len[2*i +: 2]  = r_len[i];
            bus.req_addr[42*i +: 42]  = r_addr[i];
            bus.req_mdata[16*i +: 16] = r_mdata[i];
        end
    endtask

    task automatic model_reset();
        m_active    = 0;
        m_ptr       = 0;
        m_mode      = MODE_RUN;
        m_err_len   = 1'b0;
        m_err_unf   = 1'b0;
        m_tx_valid  = 1'b0;
        m_tx_addr   = '0;
        m_tx_len    = '0;
        m_tx_mdata  = '0;
        m_rsp_valid = '0;
        m_rsp_mdata = '0;
        outq.delete();
    endtask

    task automatic predict();
        p_grant = -1;
        if (m_mode == MODE_RUN && !bus.tx_almfull) begin
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (m_ptr + k) % NR;
                if (p_grant < 0 && r_valid[i] && (m_active + lines_of(r_len[i]) <= MAX)) p_grant = i;
            end
        end
    endtask

    task automatic compare();
        predict();
        chk("req_ready", bus.req_ready, (p_grant < 0) ? 0 : (1 << p_grant));
        chk("active_lines", active_lines, m_active);
        chk("drained", drained, m_mode == MODE_DRAINED);
        chk("err_len", err_len, m_err_len);
        chk("err_underflow", err_underflow, m_err_unf);
        chk("tx_valid", bus.tx_valid, m_tx_valid);
        if (m_tx_valid) begin
            chk("tx_addr", bus.tx_addr, m_tx_addr);
            chk("tx_cl_len", bus.tx_cl_len, m_tx_len);
            chk("tx_mdata", bus.tx_mdata, m_tx_mdata);
        end
        chk("rsp_valid", bus.rsp_valid, m_rsp_valid);
        if (m_rsp_valid != 0) chk("rsp_mdata", bus.rsp_mdata, m_rsp_mdata);
    endtask

    task automatic commit();
        int add, dec, id, nxt;
        add = 0;
        dec = 0;
        m_tx_valid = 1'b0;
        if (p_grant >= 0) begin
            m_ptr = (p_grant + 1) % NR;
            if (lines_of(r_len[p_grant]) == 0) begin
                m_err_len = 1'b1;
            end else begin
                m_tx_valid = 1'b1;
                m_tx_addr  = r_addr[p_grant];
                m_tx_len   = r_len[p_grant];
                m_tx_mdata = {p_grant[0], r_mdata[p_grant][14:0]};
                add        = lines_of(r_len[p_grant]);
                repeat (add) outq.push_back(p_grant);
            end
        end
        m_rsp_valid = '0;
        if (bus.rx_rsp_valid) begin
            id          = int'(bus.rx_rsp_mdata[15]);
            m_rsp_valid = NR'(1) << id;
            m_rsp_mdata = {1'b0, bus.rx_rsp_mdata[14:0]};
            if (m_active == 0) m_err_unf = 1'b1;
            else dec = 1;
        end
        nxt = m_active + add - dec;
        case (m_mode)
            MODE_RUN:     if (quiesce) m_mode = (nxt == 0) ? MODE_DRAINED : MODE_DRAIN;
            MODE_DRAIN:   if (!quiesce) m_mode = MODE_RUN; else if (nxt == 0) m_mode = MODE_DRAINED;
            default:      if (!quiesce) m_mode = MODE_RUN;
        endcase
        m_active = nxt;
    endtask

    task automatic cycle();
        apply();
        @(negedge clk);
        compare();
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < NR; i++) begin
            r_valid[i] = 1'b0;
            r_len[i]   = 2'd0;
            r_addr[i]  = '0;
            r_mdata[i] = '0;
        end
        apply();
        bus.tx_almfull   = 1'b0;
        bus.rx_rsp_valid = 1'b0;
        bus.rx_rsp_mdata = '0;
        quiesce          = 1'b0;
        reset_n          = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_both(input logic v, input logic [1:0] len);
        for (int i = 0; i < NR; i++) begin
            r_valid[i] = v;
            r_len[i]   = len;
            r_addr[i]  = 42'({$urandom(), $urandom()});
            r_mdata[i] = 16'($urandom());
        end
    endtask

    task automatic rsp(input logic v, input logic [15:0] md);
        bus.rx_rsp_valid = v;
        bus.rx_rsp_mdata = md;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        bus.req_valid    = '0;
        bus.req_addr     = '0;
        bus.req_cl_len   = '0;
        bus.req_mdata    = '0;
        bus.tx_almfull   = 1'b0;
        bus.rx_rsp_valid = 1'b0;
        bus.rx_rsp_mdata = '0;

        do_reset();
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_tx_valid", bus.tx_valid, 0);
        chk("rst_active", active_lines, 0);
        chk("rst_drained", drained, 0);
        chk("rst_errs", {err_len, err_underflow}, 0);

        // Contention: alternating grants, tx one cycle behind carrying the ID
        set_both(1'b1, 2'd0);
        for (int k = 0; k < 6; k++) begin
            apply();
            #1;
            chk("t1_grant", bus.req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("t1_tx_valid", bus.tx_valid, k != 0);
            if (k != 0) chk("t1_tx_id", bus.tx_mdata[15], (k - 1) % 2);
            cycle();
        end

        // Credit limit at 8 lines with 4-line requests
        do_reset();
        r_valid[0] = 1'b1;
        r_len[0]   = 2'd3;
        apply();
        #1;
        chk("t2_grant_a", bus.req_ready, 2'b01);
        cycle();
        chk("t2_grant_b", bus.req_ready, 2'b01);
        cycle();
        chk("t2_stall", bus.req_ready, 2'b00);
        chk("t2_full", active_lines, 8);
        rsp(1'b1, 16'h0000);
        cycle();
        rsp(1'b0, 16'h0000);
        #1;
        chk("t2_active7", active_lines, 7);
        chk("t2_still_stall", bus.req_ready, 2'b00);
        rsp(1'b1, 16'h0001);
        repeat (3) cycle();
        rsp(1'b0, 16'h0000);
        #1;
        chk("t2_active4", active_lines, 4);
        chk("t2_resume", bus.req_ready, 2'b01);
        cycle();

        // Grant and response in the same cycle
        do_reset();
        r_valid[0] = 1'b1;
        r_len[0]   = 2'd0;
        cycle();
        r_len[0] = 2'd3;
        cycle();
        r_len[0] = 2'd1;
        rsp(1'b1, 16'h0042);
        apply();
        #1;
        chk("t3_active5", active_lines, 5);
        chk("t3_grant", bus.req_ready, 2'b01);
        cycle();
        r_valid[0] = 1'b0;
        rsp(1'b0, 16'h0000);
        apply();
        #1;
        chk("t3_active6", active_lines, 6);

        // Almost-full blocks grants, in-flight request still issues
        do_reset();
        set_both(1'b1, 2'd0);
        cycle();
        bus.tx_almfull = 1'b1;
        #1;
        chk("t4_af_ready0", bus.req_ready, 0);
        chk("t4_inflight", bus.tx_valid, 1);
        cycle();
        chk("t4_af_ready1", bus.req_ready, 0);
        chk("t4_af_tx1", bus.tx_valid, 0);
        cycle();
        chk("t4_af_ready2", bus.req_ready, 0);
        chk("t4_af_tx2", bus.tx_valid, 0);
        cycle();
        bus.tx_almfull = 1'b0;
        #1;
        chk("t4_resume", bus.req_ready, 2'b10);
        cycle();
        chk("t4_tx_after", bus.tx_valid, 1);

        // Quiesce with 3 lines in flight
        do_reset();
        set_both(1'b1, 2'd0);
        repeat (3) cycle();
        set_both(1'b0, 2'd0);
        quiesce = 1'b1;
        cycle();
        set_both(1'b1, 2'd0);
        for (int b = 0; b < 3; b++) begin
            rsp(1'b1, (b % 2 == 0) ? 16'h0010 : 16'h8010);
            apply();
            #1;
            chk("t5_no_grant", bus.req_ready, 0);
            chk("t5_not_drained", drained, 0);
            cycle();
        end
        rsp(1'b0, 16'h0000);
        #1;
        chk("t5_drained", drained, 1);
        chk("t5_drained_ready", bus.req_ready, 0);
        quiesce = 1'b0;
        #1;
        chk("t5_still_drained", drained, 1);
        cycle();
        chk("t5_resume", bus.req_ready, 2'b10);
        chk("t5_left", drained, 0);
        cycle();

        // Errors and mid-burst reset
        do_reset();
        r_valid[0] = 1'b1;
        r_len[0]   = 2'd2;
        apply();
        #1;
        chk("t6_bad_ready", bus.req_ready, 2'b01);
        cycle();
        r_valid[0] = 1'b0;
        apply();
        #1;
        chk("t6_bad_no_tx", bus.tx_valid, 0);
        chk("t6_err_len", err_len, 1);
        chk("t6_no_credit", active_lines, 0);
        rsp(1'b1, 16'h0005);
        cycle();
        rsp(1'b0, 16'h0000);
        #1;
        chk("t6_err_unf", err_underflow, 1);
        chk("t6_unf_active", active_lines, 0);
        set_both(1'b1, 2'd0);
        r_addr[0]  = 42'h2ab_cdef_0123;
        r_mdata[0] = 16'h1234;
        cycle();
        cycle();
        rsp(1'b1, 16'h8123);
        cycle();
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_ready", bus.req_ready, 0);
        chk("t6_rst_tx_valid", bus.tx_valid, 0);
        chk("t6_rst_tx_addr", bus.tx_addr, 0);
        chk("t6_rst_tx_len", bus.tx_cl_len, 0);
        chk("t6_rst_tx_mdata", bus.tx_mdata, 0);
        chk("t6_rst_rsp_valid", bus.rsp_valid, 0);
        chk("t6_rst_rsp_mdata", bus.rsp_mdata, 0);
        chk("t6_rst_active", active_lines, 0);
        chk("t6_rst_drained", drained, 0);
        chk("t6_rst_errs", {err_len, err_underflow}, 0);

        // Randomised traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NR; i++) begin
                int sel;
                sel        = $urandom_range(0, 19);
                r_valid[i] = ($urandom_range(0, 9) < 7);
                r_len[i]   = (sel == 0) ? 2'd2 : (sel < 6) ? 2'd3 : (sel < 12) ? 2'd1 : 2'd0;
                r_addr[i]  = 42'({$urandom(), $urandom()});
                r_mdata[i] = 16'($urandom());
            end
            bus.tx_almfull = ($urandom_range(0, 99) < 15);
            if ($urandom_range(0, 99) < 3) quiesce = ~quiesce;
            if (outq.size() > 0 && $urandom_range(0, 99) < 45) begin
                int id;
                id = outq.pop_front();
                rsp(1'b1, {id[0], 15'($urandom())});
            end else if (outq.size() == 0 && $urandom_range(0, 99) < 2) begin
                rsp(1'b1, 16'($urandom()));
            end else begin
                rsp(1'b0, 16'h0000);
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
